// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values, flag bit
// positions, FSM state encoding and the internal operation classes.
package alu_pkg;

    // Opcode values as presented on the opCode port
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_SLL = 5;
    localparam int OP_SRL = 6;
    localparam int OP_SRA = 7;
    localparam int OP_MUL = 8;

    // Bit positions inside the 4-bit flags bus
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operations handled by the iterative unit
    typedef enum logic [1:0] {
        IT_SLL = 2'd0,
        IT_SRL = 2'd1,
        IT_SRA = 2'd2,
        IT_MUL = 2'd3
    } iter_op_t;

    // Decoded operation class; K_ILL covers every undefined code
    typedef enum logic [3:0] {
        K_ADD = 4'd0,
        K_SUB = 4'd1,
        K_AND = 4'd2,
        K_OR  = 4'd3,
        K_XOR = 4'd4,
        K_SLL = 4'd5,
        K_SRL = 4'd6,
        K_SRA = 4'd7,
        K_MUL = 4'd8,
        K_ILL = 4'd9
    } op_kind_t;

    // Map a zero-extended opcode onto its operation class
    function automatic op_kind_t decode_op(input int code);
        op_kind_t k;
        case (code)
            OP_ADD:  k = K_ADD;
            OP_SUB:  k = K_SUB;
            OP_AND:  k = K_AND;
            OP_OR:   k = K_OR;
            OP_XOR:  k = K_XOR;
            OP_SLL:  k = K_SLL;
            OP_SRL:  k = K_SRL;
            OP_SRA:  k = K_SRA;
            OP_MUL:  k = K_MUL;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath for shifts (one bit per step) and unsigned
// shift-add multiply (one multiplier bit per step). The low half of the
// data register holds the shift operand or, for MUL, the multiplier that
// is consumed as the partial product grows into the upper half.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SHAMT_WIDTH = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   start,
    input  logic                   step,
    input  logic [1:0]             op,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   last,
    output logic [WIDTH-1:0]       result,
    output logic                   carry,
    output logic                   overflow
);

    // One extra bit so the counter can hold WIDTH for multiply
    localparam int CW = SHAMT_WIDTH + 1;

    logic [2*WIDTH-1:0] data_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [CW-1:0]      count_q;
    logic               carry_q;
    iter_op_t           op_q;
    logic [WIDTH:0]     mul_sum;
    logic               hi_nz;

    // Partial-product add for the current multiplier bit (LSB of data)
    always_comb begin
        mul_sum = {1'b0, data_q[2*WIDTH-1:WIDTH]};
        if (data_q[0]) begin
            mul_sum = {1'b0, data_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end
    end

    // Load operands on start, then advance one bit per step until the count expires
    always_ff @(posedge clk) begin
        if (!resetN) begin
            data_q  <= '0;
            mcand_q <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            op_q    <= IT_SLL;
        end else if (start) begin
            op_q    <= iter_op_t'(op);
            mcand_q <= a;
            carry_q <= 1'b0;
            if (iter_op_t'(op) == IT_MUL) begin
                data_q  <= {{WIDTH{1'b0}}, b};
                count_q <= CW'(WIDTH);
            end else begin
                data_q  <= {{WIDTH{1'b0}}, a};
                count_q <= {1'b0, shamt};
            end
        end else if (step && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
            case (op_q)
                IT_SLL: begin
                    carry_q            <= data_q[WIDTH-1];
                    data_q[WIDTH-1:0]  <= {data_q[WIDTH-2:0], 1'b0};
                end
                IT_SRL: begin
                    carry_q            <= data_q[0];
                    data_q[WIDTH-1:0]  <= {1'b0, data_q[WIDTH-1:1]};
                end
                IT_SRA: begin
                    carry_q            <= data_q[0];
                    data_q[WIDTH-1:0]  <= {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                end
                default: begin
                    data_q <= {mul_sum, data_q[WIDTH-1:1]};
                end
            endcase
        end
    end

    // Status decode from the registered state only
    always_comb begin
        hi_nz    = |data_q[2*WIDTH-1:WIDTH];
        last     = (count_q == CW'(1));
        result   = data_q[WIDTH-1:0];
        carry    = carry_q;
        overflow = 1'b0;
        if (op_q == IT_MUL) begin
            carry    = hi_nz;
            overflow = hi_nz;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU. Single-cycle operations are computed at the
// accept edge and registered; shifts and multiply run in alu_iter_unit and
// their result is read straight from its registers once DONE is reached.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int OPCODE_WIDTH = 6,
    parameter int SHAMT_WIDTH  = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [WIDTH-1:0]        operand1,
    input  logic [WIDTH-1:0]        operand2,
    input  logic [OPCODE_WIDTH-1:0] opCode,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [WIDTH-1:0]        result,
    output logic [3:0]              flags,
    output logic                    error
);

    state_t             state_q, state_d;
    op_kind_t           kind;
    logic               accept;
    logic               is_iter;
    logic               iter_start;
    logic               iter_step;
    logic [1:0]         iter_op;
    logic [SHAMT_WIDTH-1:0] shamt;

    logic               iter_last;
    logic [WIDTH-1:0]   iter_result;
    logic               iter_carry;
    logic               iter_overflow;

    logic [WIDTH-1:0]   sc_res;
    logic               sc_c;
    logic               sc_v;
    logic               sc_err;
    logic [WIDTH:0]     usum;
    logic [WIDTH:0]     udiff;
    logic signed [WIDTH:0] ssum;
    logic signed [WIDTH:0] sdiff;

    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flags_q;
    logic               error_q;
    logic               use_iter_q;

    // Opcode decode and iterative-unit control
    always_comb begin
        kind       = decode_op(int'(opCode));
        shamt      = operand2[SHAMT_WIDTH-1:0];
        accept     = inValid && (state_q == IDLE);
        is_iter    = (kind == K_SLL) || (kind == K_SRL) ||
                     (kind == K_SRA) || (kind == K_MUL);
        iter_start = accept && is_iter;
        iter_step  = (state_q == BUSY);
        iter_op    = IT_SLL;
        case (kind)
            K_SRL:   iter_op = IT_SRL;
            K_SRA:   iter_op = IT_SRA;
            K_MUL:   iter_op = IT_MUL;
            default: iter_op = IT_SLL;
        endcase
    end

    alu_iter_unit #(
        .WIDTH       (WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_iter (
        .clk      (clk),
        .resetN   (resetN),
        .start    (iter_start),
        .step     (iter_step),
        .op       (iter_op),
        .a        (operand1),
        .b        (operand2),
        .shamt    (shamt),
        .last     (iter_last),
        .result   (iter_result),
        .carry    (iter_carry),
        .overflow (iter_overflow)
    );

    // Single-cycle arithmetic/logic result and carry/overflow
    always_comb begin
        usum   = {1'b0, operand1} + {1'b0, operand2};
        udiff  = {1'b0, operand1} - {1'b0, operand2};
        ssum   = $signed({operand1[WIDTH-1], operand1}) + $signed({operand2[WIDTH-1], operand2});
        sdiff  = $signed({operand1[WIDTH-1], operand1}) - $signed({operand2[WIDTH-1], operand2});
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        case (kind)
            K_ADD: begin
                sc_res = usum[WIDTH-1:0];
                sc_c   = usum[WIDTH];
                sc_v   = ssum[WIDTH] ^ ssum[WIDTH-1];
            end
            K_SUB: begin
                sc_res = udiff[WIDTH-1:0];
                sc_c   = udiff[WIDTH];
                sc_v   = sdiff[WIDTH] ^ sdiff[WIDTH-1];
            end
            K_AND:   sc_res = operand1 & operand2;
            K_OR:    sc_res = operand1 | operand2;
            K_XOR:   sc_res = operand1 ^ operand2;
            K_ILL:   sc_err = 1'b1;
            default: sc_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero-length shifts finish like single-cycle ops
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    if (kind == K_MUL) begin
                        state_d = BUSY;
                    end else if (is_iter && (shamt != '0)) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                if (iter_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the single-cycle result and flags at the accept edge
    always_ff @(posedge clk) begin
        if (!resetN) begin
            result_q   <= '0;
            flags_q    <= '0;
            error_q    <= 1'b0;
            use_iter_q <= 1'b0;
        end else if (accept) begin
            result_q        <= sc_res;
            flags_q[FLAG_Z] <= (sc_res == '0);
            flags_q[FLAG_N] <= sc_res[WIDTH-1];
            flags_q[FLAG_C] <= sc_c;
            flags_q[FLAG_V] <= sc_v;
            error_q         <= sc_err;
            use_iter_q      <= is_iter;
        end
    end

    // Output selection from registered sources only
    always_comb begin
        inReady  = (state_q == IDLE);
        outValid = (state_q == DONE);
        error    = error_q;
        result   = result_q;
        flags    = flags_q;
        if (use_iter_q) begin
            result        = iter_result;
            flags[FLAG_Z] = (iter_result == '0);
            flags[FLAG_N] = iter_result[WIDTH-1];
            flags[FLAG_C] = iter_carry;
            flags[FLAG_V] = iter_overflow;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): reset state, every opcode class,
// latency, backpressure, reset during multiply and illegal opcodes.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [5:0]  opCode;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.WIDTH(32), .OPCODE_WIDTH(6)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .inValid  (inValid),
        .inReady  (inReady),
        .operand1 (operand1),
        .operand2 (operand2),
        .opCode   (opCode),
        .outValid (outValid),
        .outReady (outReady),
        .result   (result),
        .flags    (flags),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Offer one op; returns after the accept edge. lat counts edges from the
    // accept edge (inclusive) until outValid is seen, bounded by 100.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk);
        opCode   = op;
        operand1 = a;
        operand2 = b;
        inValid  = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({inReady, outValid, result, flags, error} !== {1'b1, 1'b0, 32'h0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: inReady=%b outValid=%b result=%h flags=%b error=%b, want 1 0 00000000 0000 0",
                     inReady, outValid, result, flags, error);
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_add();
        int lat;
        do_op(6'd0, 32'd2, 32'd3, lat);
        n_checks++;
        if (lat !== 1 || result !== 32'd5 || flags !== 4'b0000 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL add_2_3: lat=%0d result=%h flags=%b error=%b, want 1 00000005 0000 0", lat, result, flags, error);
        end
        release_result();
        n_checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL add_release: outValid=%b inReady=%b, want 0 1", outValid, inReady);
        end
        do_op(6'd0, 32'hFFFF_FFFF, 32'd1, lat);
        n_checks++;
        if (result !== 32'h0 || flags !== 4'b0101) begin
            n_fail++;
            $display("FAIL add_wrap: result=%h flags=%b, want 00000000 0101", result, flags);
        end
        release_result();
        do_op(6'd0, 32'h7FFF_FFFF, 32'd1, lat);
        n_checks++;
        if (result !== 32'h8000_0000 || flags !== 4'b1010) begin
            n_fail++;
            $display("FAIL add_ovf: result=%h flags=%b, want 80000000 1010", result, flags);
        end
        release_result();
    endtask

    task automatic test_logic();
        logic [5:0]  ops  [4] = '{6'd1, 6'd2, 6'd3, 6'd4};
        logic [31:0] exp_r[4] = '{32'hFFFF_FFFF, 32'd2, 32'd3, 32'd1};
        logic [3:0]  exp_f[4] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], 32'd2, 32'd3, lat);
            n_checks++;
            if (lat !== 1 || result !== exp_r[i] || flags !== exp_f[i] || error !== 1'b0) begin
                n_fail++;
                $display("FAIL logic_op%0d: lat=%0d result=%h flags=%b error=%b, want 1 %h %b 0",
                         ops[i], lat, result, flags, error, exp_r[i], exp_f[i]);
            end
            release_result();
        end
    endtask

    task automatic test_shift();
        int lat;
        do_op(6'd7, 32'h8000_0000, 32'd4, lat);
        n_checks++;
        if (lat !== 5 || result !== 32'hF800_0000 || flags !== 4'b0010) begin
            n_fail++;
            $display("FAIL sra_4: lat=%0d result=%h flags=%b, want 5 f8000000 0010", lat, result, flags);
        end
        release_result();
        do_op(6'd5, 32'h1234_5678, 32'hFFFF_FFE0, lat);
        n_checks++;
        if (lat !== 1 || result !== 32'h1234_5678 || flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL sll_0: lat=%0d result=%h flags=%b, want 1 12345678 0000", lat, result, flags);
        end
        release_result();
        do_op(6'd6, 32'h0000_0003, 32'd1, lat);
        n_checks++;
        if (lat !== 2 || result !== 32'h1 || flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL srl_1: lat=%0d result=%h flags=%b, want 2 00000001 0100", lat, result, flags);
        end
        release_result();
        do_op(6'd5, 32'h8000_0001, 32'd1, lat);
        n_checks++;
        if (lat !== 2 || result !== 32'h2 || flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL sll_1: lat=%0d result=%h flags=%b, want 2 00000002 0100", lat, result, flags);
        end
        release_result();
        do_op(6'd6, 32'hF000_0000, 32'd31, lat);
        n_checks++;
        if (lat !== 32 || result !== 32'h1 || flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL srl_31: lat=%0d result=%h flags=%b, want 32 00000001 0100", lat, result, flags);
        end
        release_result();
    endtask

    task automatic test_mul();
        int lat;
        do_op(6'd8, 32'h0001_0000, 32'h0001_0000, lat);
        n_checks++;
        if (lat !== 33 || result !== 32'h0 || flags !== 4'b1101 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_big: lat=%0d result=%h flags=%b error=%b, want 33 00000000 1101 0", lat, result, flags, error);
        end
        release_result();
        do_op(6'd8, 32'd7, 32'd6, lat);
        n_checks++;
        if (lat !== 33 || result !== 32'd42 || flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL mul_7_6: lat=%0d result=%h flags=%b, want 33 0000002a 0000", lat, result, flags);
        end
        release_result();
        do_op(6'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        n_checks++;
        if (result !== 32'h1 || flags !== 4'b1100) begin
            n_fail++;
            $display("FAIL mul_max: result=%h flags=%b, want 00000001 1100", result, flags);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(6'd0, 32'd2, 32'd3, lat);
        @(negedge clk);
        inValid  = 1'b1;
        opCode   = 6'd1;
        operand1 = 32'd9;
        operand2 = 32'd9;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (outValid !== 1'b1 || inReady !== 1'b0 || result !== 32'd5 || flags !== 4'b0000) begin
                n_fail++;
                $display("FAIL hold_%0d: outValid=%b inReady=%b result=%h flags=%b, want 1 0 00000005 0000",
                         i, outValid, inReady, result, flags);
            end
        end
        @(negedge clk);
        inValid = 1'b0;
        release_result();
        n_checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: outValid=%b inReady=%b, want 0 1", outValid, inReady);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (outValid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_ignored: outValid=%b, want 0", outValid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        @(negedge clk);
        opCode   = 6'd8;
        operand1 = 32'd7;
        operand2 = 32'd6;
        inValid  = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        resetN = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mul: inReady=%b outValid=%b result=%h flags=%b, want 1 0 00000000 0000",
                     inReady, outValid, result, flags);
        end
        @(negedge clk);
        resetN = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mul_quiet: outValid=%b inReady=%b, want 0 1", outValid, inReady);
        end
        do_op(6'd0, 32'd10, 32'd20, lat);
        n_checks++;
        if (lat !== 1 || result !== 32'd30) begin
            n_fail++;
            $display("FAIL after_reset_add: lat=%0d result=%h, want 1 0000001e", lat, result);
        end
        release_result();
    endtask

    task automatic test_illegal();
        int lat;
        do_op(6'h3F, 32'h1234, 32'h5678, lat);
        n_checks++;
        if (lat !== 1 || result !== 32'h0 || flags !== 4'b0001 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_3f: lat=%0d result=%h flags=%b error=%b, want 1 00000000 0001 1", lat, result, flags, error);
        end
        release_result();
        do_op(6'd9, 32'h1, 32'h1, lat);
        n_checks++;
        if (result !== 32'h0 || flags !== 4'b0001 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_9: result=%h flags=%b error=%b, want 00000000 0001 1", result, flags, error);
        end
        release_result();
        do_op(6'd4, 32'hF0F0_F0F0, 32'hF0F0_F0F0, lat);
        n_checks++;
        if (result !== 32'h0 || flags !== 4'b0001 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL xor_zero: result=%h flags=%b error=%b, want 00000000 0001 0", result, flags, error);
        end
        release_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN   = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        operand1 = '0;
        operand2 = '0;
        opCode   = '0;
        test_reset();
        test_add();
        test_logic();
        test_shift();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the combinational 32-bit ALU. Adds configurable datapath width, registered results with status flags, and iterative multi-cycle shift and multiply operations. Sits between operand fetch and writeback in the microprocessor datapath. Uses a valid/ready handshake on both sides and processes one operation at a time.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and a power of two.
- OPCODE_WIDTH, 6: opcode width.
- SHAMT_WIDTH, $clog2(WIDTH): number of operand2 LSBs used as shift amount.
- clk  input  1  system clock; all state updates on the rising edge.
- resetN  input  1  reset; synchronous, active-low.
- inValid  input  1  operation offered.
- inReady  output  1  block can accept; high only in IDLE.
- operand1  input  WIDTH  first operand.
- operand2  input  WIDTH  second operand; shift amount in its SHAMT_WIDTH LSBs.
- opCode  input  OPCODE_WIDTH  operation select.
- outValid  output  1  result/flags valid; high only in DONE.
- outReady  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- flags  output  4  {overflow, carry, negative, zero} = bits [3:0] as [3]=overflow, [2]=carry, [1]=negative, [0]=zero.
- error  output  1  result was produced from an undefined opcode.

## Operation
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, MUL=8. All other codes are illegal.
- States:
  - IDLE: inReady=1. Accept on inValid&&inReady; latch operands and opcode.
  - BUSY: iterative step each cycle; counter decrements; go to DONE when the counter reaches 0.
  - DONE: outValid=1; result, flags, error held stable; go to IDLE on outReady.
- Transitions from IDLE on accept:
  - ADD, SUB, AND, OR, XOR, illegal → DONE.
  - Shift with shamt=0 → DONE.
  - Shift with shamt>0 → BUSY, count=shamt.
  - MUL → BUSY, count=WIDTH.
- Shifts move one bit per BUSY cycle. SRA replicates the MSB.
- MUL is unsigned shift-add, one multiplier bit per cycle. Internal product is 2·WIDTH bits; result is the low WIDTH bits.
- Arithmetic is modulo 2^WIDTH.
- zero = (result==0); negative = result[WIDTH-1].
- ADD:
  - carry = unsigned carry-out.
  - overflow = signed overflow.
- SUB:
  - carry = borrow, i.e. operand1 <u operand2.
  - overflow = signed overflow.
- AND/OR/XOR: carry=0, overflow=0.
- Shifts:
  - carry = last bit shifted out; 0 when shamt=0.
  - overflow = 0.
- MUL: carry = overflow = (high WIDTH bits of product ≠ 0).
- Illegal opcode: result=0, flags=4'b0001, error=1. error is 0 for all legal ops.
- inValid, operands and opCode are ignored outside IDLE.

## Timing
- Reset (resetN=0 at an edge) forces:
  - state IDLE;
  - result=0, flags=0, error=0;
  - outValid=0, inReady=1;
  - counter and internal registers cleared.
- Reset is valid from any state. An in-flight BUSY or DONE operation is discarded and no result is emitted.
- Latency, with the accept edge at k; outValid is high after edge:
  - single-cycle ops: k+1;
  - shifts: k+1+shamt;
  - MUL: k+1+WIDTH.
- In DONE, outValid stays high and outputs stay constant until the edge where outReady=1. outValid is low after that edge.
- inReady rises in the cycle after the handshake. Back-to-back throughput for single-cycle ops is one op per 2 cycles.
- No combinational path from inputs to outValid, result or flags. inReady is a pure state decode.

## Structure
- Package alu_pkg holds:
  - opcode localparams (ADD…MUL);
  - flag bit indices (FLAG_Z, FLAG_N, FLAG_C, FLAG_V);
  - state encoding (IDLE, BUSY, DONE).
- One sub-module, alu_iter_unit: the shift/multiply datapath registers and counter, with start/step/done signals. The top holds the FSM, single-cycle ops, flag logic and handshake.

## Test plan
- ADD, WIDTH=32: 2 + 3 → result 5, flags 0000, outValid one cycle after accept. Then 0xFFFFFFFF + 1 → result 0, zero=1, carry=1.
- SUB, AND, OR, XOR on 2, 3 →
  - SUB: 0xFFFFFFFF with negative=1, carry=1;
  - AND: 2; OR: 3; XOR: 1;
  - overflow=0 for all four.
- SRA 0x80000000 by 4 → 0xF8000000, negative=1, carry=0, outValid after edge k+5. SLL by 0 → unchanged, latency 1.
- MUL 0x00010000 × 0x00010000 → result 0, zero=1, carry=1, overflow=1, latency 33. Also 7 × 6 → 42 with flags 0.
- Backpressure: hold outReady=0 for 3 cycles in DONE → result and flags stable, inReady=0, new inValid ignored. Result accepted on the first outReady=1.
- resetN=0 mid-MUL (cycle 10) → next cycle IDLE, outValid=0, result=0. Illegal opCode 6'h3F → result 0, flags 0001, error=1.
